// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output scheduler.
package audio_pkg;

    localparam int SAMPLE_W = 32;
    localparam int MIN_DIV  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sample_rate_divider.sv
// Free-running period counter: pulses tick on the last cycle of each period
// and restarts from zero whenever clear is held.
module sample_rate_divider #(
    parameter int DIV_W = 16
) (
    input  logic             c,
    input  logic             r,
    input  logic             clear,
    input  logic [DIV_W-1:0] div_l,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             wrap;

    always_comb begin
        wrap  = (cnt_q == (div_l - DIV_W'(1)));
        tick  = !clear && wrap;
        cnt_d = cnt_q + DIV_W'(1);
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_output_scheduler.sv
// Paces a one-entry sample buffer onto x at a programmable period, counting
// underruns and stopping after a programmed number of ticks.
module audio_output_scheduler
    import audio_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DIV_W = 16,
    parameter int LEN_W = 32,
    parameter int UC_W  = 16
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [W-1:0]     x,
    output logic             x_stb,
    output logic             busy,
    output logic             done,
    output logic [UC_W-1:0]  underrun_cnt
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic [LEN_W-1:0] len_l_q, len_l_d;
    logic [LEN_W-1:0] played_q, played_d;
    logic             buf_full_q, buf_full_d;
    logic [W-1:0]     buf_q, buf_d;
    logic [W-1:0]     x_q, x_d;
    logic             x_stb_q, x_stb_d;
    logic [UC_W-1:0]  underrun_q, underrun_d;
    logic             tick;
    logic             xfer;

    sample_rate_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .c    (c),
        .r    (r),
        .clear(state_q != ST_RUN),
        .div_l(div_l_q),
        .tick (tick)
    );

    assign s_ready      = (state_q == ST_RUN) && !buf_full_q;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign x            = x_q;
    assign x_stb        = x_stb_q;
    assign underrun_cnt = underrun_q;
    assign xfer         = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        div_l_d    = div_l_q;
        len_l_d    = len_l_q;
        played_d   = played_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        x_d        = x_q;
        x_stb_d    = 1'b0;
        underrun_d = underrun_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d    = ST_RUN;
                    div_l_d    = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
                    len_l_d    = len;
                    played_d   = '0;
                    underrun_d = '0;
                    buf_full_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // Disable wins over a coincident tick: nothing is strobed out.
                    state_d    = ST_IDLE;
                    buf_full_d = 1'b0;
                end else begin
                    if (tick) begin
                        x_stb_d  = 1'b1;
                        played_d = played_q + LEN_W'(1);
                        if (buf_full_q) begin
                            x_d        = buf_q;
                            buf_full_d = 1'b0;
                        end else if (underrun_q != '1) begin
                            underrun_d = underrun_q + UC_W'(1);
                        end
                    end
                    // Only possible with an empty buffer, so it never collides with a drain.
                    if (xfer) begin
                        buf_full_d = 1'b1;
                        buf_d      = s_data;
                    end
                    if (tick && (len_l_q != '0) && (played_d == len_l_q)) begin
                        state_d    = ST_DONE;
                        buf_full_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                buf_full_d = 1'b0;
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                buf_full_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (r) begin
            state_q    <= ST_IDLE;
            div_l_q    <= DIV_W'(MIN_DIV);
            len_l_q    <= '0;
            played_q   <= '0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            x_q        <= '0;
            x_stb_q    <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            div_l_q    <= div_l_d;
            len_l_q    <= len_l_d;
            played_q   <= played_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            x_q        <= x_d;
            x_stb_q    <= x_stb_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
